remap_accel_hls_deadlock_report_unit: RTL and testbench
=======================================================

Name: remap_accel_hls_deadlock_report_unit

Overview:
Central collector downstream of the per-process deadlock detect units in remap_accel. Consumes each unit's dl_detect_out and token arrivals, and confirms a deadlock only when it persists. It then broadcasts the global detect flag, fires a one-hot origin to launch the trace token, and records every process the token visits. Visited process IDs go out through a valid/ready report port, and the unit finally issues token_clear.

Parameters:
PROC_NUM, 4, number of dataflow processes (one detect unit each); >=2
STABLE_CYCLES, 16, consecutive cycles a dl_detect bit must stay high before confirmation; >=1
TRACE_TIMEOUT, 64, max cycles without a new visited process during trace before abort; >=2
ID_W, derived = max(1, clog2(PROC_NUM)), process ID width (localparam)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
dl_detect_vec  input  PROC_NUM  bit p = dl_detect_out of process p's detect unit
token_vec  input  PROC_NUM  bit p = OR of token_in_vec at process p's detect unit
dl_detect_global  output  1  drives every unit's dl_detect_in
origin  output  PROC_NUM  one-hot, one-cycle pulse to the chosen unit's origin
token_clear  output  1  one-cycle pulse broadcast to all units' token_clear
report_valid  output  1  report entry available
report_ready  input  1  consumer accepts entry when valid&ready
report_proc_id  output  ID_W  visited process ID; first entry is always the origin
report_last  output  1  marks final entry of a trace
deadlock_flag  output  1  sticky; deadlock confirmed and trace complete
timeout_flag  output  1  sticky; trace aborted by TRACE_TIMEOUT

Behaviour:
- Reset (async, reset==0): all outputs 0, FSM=IDLE, counters 0, FIFO empty, visited mask 0.
- FSM states: IDLE, CONFIRM, LAUNCH, TRACE, CLEAR, DRAIN, DONE.
- IDLE: when |dl_detect_vec, latch cand = lowest set index, set cnt=1, go CONFIRM.
- CONFIRM: if dl_detect_vec[cand]==0, go IDLE (cnt=0). Else cnt++. At cnt==STABLE_CYCLES, set dl_detect_global=1 (registered, held until DONE exit or reset) and go LAUNCH. With STABLE_CYCLES=1, confirmation happens in the cycle after IDLE detection.
- LAUNCH (1 cycle): origin = 1<<cand. Push cand to FIFO, set visited[cand], clear timeout counter, go TRACE.
- TRACE, each cycle:
  - Let new = token_vec & ~visited.
  - If new!=0, push lowest-index bit of new, set that visited bit, and reset the timeout counter. Only one push per cycle; other new bits are taken on later cycles while they stay high.
  - If token_vec[cand]==1 (token returned to origin), mark the last pushed entry as report_last and go CLEAR. This check has priority over a push in the same cycle: that push is discarded.
  - Otherwise increment the timeout counter. At TRACE_TIMEOUT, set timeout_flag, mark last entry, go CLEAR.
- CLEAR (1 cycle): token_clear=1, go DRAIN.
- DRAIN: wait for FIFO empty, then set deadlock_flag=1 (unless timeout_flag), go DONE.
- DONE: terminal (see optional feature). dl_detect_global stays 1.
- FIFO: depth PROC_NUM. Each process is pushed at most once per trace, so overflow is impossible. Pushes continue while the output is stalled.
- Report handshake:
  - report_valid = ~empty.
  - Entry pops on valid&ready.
  - report_proc_id and report_last are stable while valid&~ready.
  - Push and pop in the same cycle are both honoured.
  - Zero-latency bypass is not allowed: an entry appears one cycle after its push.
- Simultaneous dl_detect bits in IDLE: the lowest index wins; the others are ignored until the next IDLE pass.
- origin and token_clear never assert in the same cycle, and never outside LAUNCH/CLEAR.

Optional Feature:
HLS_DL_REPORT_RESTART_EN
- Defined: DONE counts cycles with dl_detect_vec==0. After STABLE_CYCLES such consecutive cycles, the unit returns to IDLE and clears dl_detect_global, deadlock_flag, timeout_flag and visited. Any nonzero bit restarts the count.
- Undefined: DONE is terminal until reset; this counter is not built.

Test Plan:
- PROC_NUM=4, STABLE_CYCLES=16: dl_detect_vec[2] high 10 cycles then low -> returns to IDLE; no origin, dl_detect_global stays 0.
- dl_detect_vec=4'b0110 held -> dl_detect_global rises 16 cycles after entering CONFIRM; origin=4'b0010 for exactly 1 cycle.
- After origin=1 (cand=1): token_vec walks 3 (cycle 2), 0 (cycle 4), 1 (cycle 6), report_ready=1 -> reports 1,3,0 with report_last on 0; token_clear pulses once; deadlock_flag=1.
- Same trace with report_ready=0 until CLEAR, then 1 -> all 3 entries delivered in order, no loss, deadlock_flag only after the FIFO drains.
- TRACE_TIMEOUT=64 with no token_vec activity after launch -> timeout_flag=1, single entry (origin) with report_last, token_clear pulse, deadlock_flag=0.
- reset asserted mid-TRACE -> all outputs 0 immediately (async); after release dl_detect_vec=0 -> remains IDLE.

Source files
------------

// File: rtl/remap_accel_hls_deadlock_report_unit.sv
// Deadlock report collector for remap_accel: confirms a persistent dl_detect, launches the trace token and
// reports every visited process. Optional macro HLS_DL_REPORT_RESTART_EN re-arms the unit from DONE.
module remap_accel_hls_deadlock_report_unit #(
    parameter int PROC_NUM       = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TRACE_TIMEOUT  = 64,
    localparam int ID_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_vec,
    output logic                dl_detect_global,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [ID_W-1:0]     report_proc_id,
    output logic                report_last,
    output logic                deadlock_flag,
    output logic                timeout_flag
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TRACE_TIMEOUT);
    localparam int OCC_W = $clog2(PROC_NUM + 1);

    typedef enum logic [2:0] {IDLE, CONFIRM, LAUNCH, TRACE, CLEAR, DRAIN, DONE} state_t;

    state_t              state_reg;
    logic [ID_W-1:0]     cand_reg;
    logic [ID_W-1:0]     pend_id_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [TO_W-1:0]     tcnt_reg;
    logic [PROC_NUM-1:0] visited_reg;
    logic [ID_W:0]       fifo_mem [PROC_NUM];
    logic [ID_W-1:0]     rd_ptr_reg;
    logic [ID_W-1:0]     wr_ptr_reg;
    logic [OCC_W-1:0]    occ_reg;
    logic [PROC_NUM-1:0] new_vec;
    logic [ID_W-1:0]     new_id;
    logic                returned;
    logic                timed_out;
    logic                wr_en;
    logic                wr_last;
    logic                rd_en;
    logic [ID_W:0]       head;
`ifdef HLS_DL_REPORT_RESTART_EN
    logic [CNT_W-1:0]    quiet_reg;
`endif

    function automatic logic [ID_W-1:0] lowest_index(input logic [PROC_NUM-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [PROC_NUM-1:0] one_hot(input logic [ID_W-1:0] id);
        return {{(PROC_NUM-1){1'b0}}, 1'b1} << id;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
        return (p == ID_W'(PROC_NUM - 1)) ? '0 : p + ID_W'(1);
    endfunction

    // The most recent visit is held in pend_id_reg so it can still be tagged as last
    // when the trace ends; it enters the FIFO when the next visit or the trace end arrives.
    always_comb begin
        new_vec   = token_vec & ~visited_reg;
        new_id    = lowest_index(new_vec);
        returned  = 1'b0;
        timed_out = 1'b0;
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        if (state_reg == TRACE) begin
            if (|(token_vec & one_hot(cand_reg))) begin
                returned = 1'b1;
                wr_en    = 1'b1;
                wr_last  = 1'b1;
            end else if (|new_vec) begin
                wr_en = 1'b1;
            end else if (tcnt_reg == TO_W'(TRACE_TIMEOUT - 1)) begin
                timed_out = 1'b1;
                wr_en     = 1'b1;
                wr_last   = 1'b1;
            end
        end
    end

    assign head           = fifo_mem[rd_ptr_reg];
    assign report_valid   = (occ_reg != '0);
    assign rd_en          = report_valid & report_ready;
    assign report_proc_id = report_valid ? head[ID_W-1:0] : '0;
    assign report_last    = report_valid & head[ID_W];

    always_ff @(posedge clock) begin
        if (wr_en) fifo_mem[wr_ptr_reg] <= {wr_last, pend_id_reg};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (rd_en) rd_ptr_reg <= next_ptr(rd_ptr_reg);
            if (wr_en && !rd_en)      occ_reg <= occ_reg + OCC_W'(1);
            else if (!wr_en && rd_en) occ_reg <= occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cand_reg         <= '0;
            pend_id_reg      <= '0;
            cnt_reg          <= '0;
            tcnt_reg         <= '0;
            visited_reg      <= '0;
            dl_detect_global <= 1'b0;
            origin           <= '0;
            token_clear      <= 1'b0;
            deadlock_flag    <= 1'b0;
            timeout_flag     <= 1'b0;
`ifdef HLS_DL_REPORT_RESTART_EN
            quiet_reg        <= '0;
`endif
        end else begin
            origin      <= '0;
            token_clear <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|dl_detect_vec) begin
                        cand_reg  <= lowest_index(dl_detect_vec);
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!(|(dl_detect_vec & one_hot(cand_reg)))) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_W'(STABLE_CYCLES)) begin
                        dl_detect_global <= 1'b1;
                        origin           <= one_hot(cand_reg);
                        state_reg        <= LAUNCH;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    pend_id_reg <= cand_reg;
                    visited_reg <= visited_reg | one_hot(cand_reg);
                    tcnt_reg    <= '0;
                    state_reg   <= TRACE;
                end
                TRACE: begin
                    if (returned) begin
                        token_clear <= 1'b1;
                        state_reg   <= CLEAR;
                    end else if (|new_vec) begin
                        pend_id_reg <= new_id;
                        visited_reg <= visited_reg | one_hot(new_id);
                        tcnt_reg    <= '0;
                    end else if (timed_out) begin
                        timeout_flag <= 1'b1;
                        token_clear  <= 1'b1;
                        state_reg    <= CLEAR;
                    end else begin
                        tcnt_reg <= tcnt_reg + TO_W'(1);
                    end
                end
                CLEAR: state_reg <= DRAIN;
                DRAIN: begin
                    if (occ_reg == '0) begin
                        deadlock_flag <= ~timeout_flag;
                        state_reg     <= DONE;
                    end
                end
`ifdef HLS_DL_REPORT_RESTART_EN
                DONE: begin
                    if (|dl_detect_vec) begin
                        quiet_reg <= '0;
                    end else if (quiet_reg == CNT_W'(STABLE_CYCLES - 1)) begin
                        quiet_reg        <= '0;
                        cnt_reg          <= '0;
                        visited_reg      <= '0;
                        dl_detect_global <= 1'b0;
                        deadlock_flag    <= 1'b0;
                        timeout_flag     <= 1'b0;
                        state_reg        <= IDLE;
                    end else begin
                        quiet_reg <= quiet_reg + CNT_W'(1);
                    end
                end
`else
                DONE: state_reg <= DONE;
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_remap_accel_hls_deadlock_report_unit.sv
// Self-checking bench for remap_accel_hls_deadlock_report_unit: confirmation table, directed traces,
// randomized traces against a list-level reference model, and asynchronous reset mid-trace.
module tb_remap_accel_hls_deadlock_report_unit;
    localparam int PN   = 4;
    localparam int SC   = 16;
    localparam int TO   = 64;
    localparam int MAXC = 200;

    logic          clock;
    logic          reset;
    logic [PN-1:0] dl_detect_vec;
    logic [PN-1:0] token_vec;
    logic          dl_detect_global;
    logic [PN-1:0] origin;
    logic          token_clear;
    logic          report_valid;
    logic          report_ready;
    logic [1:0]    report_proc_id;
    logic          report_last;
    logic          deadlock_flag;
    logic          timeout_flag;

    int checks = 0;
    int errors = 0;

    logic [PN-1:0] tv [MAXC];
    int  exp_q[$];
    bit  exp_to;
    int  got_id[$];
    bit  got_last[$];

    typedef struct {
        logic [PN-1:0] dl;
        int            hold;
        bit            exp_g;
        logic [PN-1:0] exp_o;
        int            exp_rise;
    } vec_t;
    vec_t tbl [6];

    remap_accel_hls_deadlock_report_unit #(
        .PROC_NUM(PN), .STABLE_CYCLES(SC), .TRACE_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .dl_detect_vec(dl_detect_vec), .token_vec(token_vec),
        .dl_detect_global(dl_detect_global), .origin(origin), .token_clear(token_clear),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_proc_id(report_proc_id), .report_last(report_last),
        .deadlock_flag(deadlock_flag), .timeout_flag(timeout_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        dl_detect_vec = '0;
        token_vec = '0;
        report_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Reference: origin first, then each cycle the lowest not-yet-visited token bit;
    // stop when the origin bit returns or after TO consecutive cycles without a new visit.
    task automatic model(input int orig);
        logic [PN-1:0] vis;
        int idle;
        exp_q.delete();
        exp_q.push_back(orig);
        vis = '0;
        vis[orig] = 1'b1;
        idle = 0;
        exp_to = 1'b0;
        for (int c = 1; c < MAXC; c++) begin
            if (tv[c][orig]) break;
            if ((tv[c] & ~vis) != '0) begin
                for (int p = 0; p < PN; p++) begin
                    if (tv[c][p] && !vis[p]) begin
                        exp_q.push_back(p);
                        vis[p] = 1'b1;
                        break;
                    end
                end
                idle = 0;
            end else begin
                idle++;
                if (idle == TO) begin
                    exp_to = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic launch(input int orig);
        bit seen;
        do_reset();
        dl_detect_vec = PN'(1 << orig);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clock); #1;
            if (origin != '0) seen = 1'b1;
        end
        chk("launch_seen", 32'(seen), 1);
        chk("launch_origin", 32'(origin), 32'(1 << orig));
        chk("launch_global", 32'(dl_detect_global), 1);
        dl_detect_vec = '0;
        token_vec = '0;
    endtask

    // mode 0: ready always high, 1: ready low until token_clear, 2: random ready
    task automatic run_trace(input int mode, input string name);
        int  clr_cnt, org_cnt, overlap, early_dl, after;
        bit  stall, done, slast;
        logic [1:0] sid;
        clr_cnt = 0; org_cnt = 0; overlap = 0; early_dl = 0; after = 0;
        stall = 1'b0; done = 1'b0; slast = 1'b0; sid = '0;
        got_id.delete();
        got_last.delete();
        for (int c = 1; c <= 400 && !done; c++) begin
            @(posedge clock); #1;
            if (stall) begin
                chk("hold_valid", 32'(report_valid), 1);
                chk("hold_id", 32'(report_proc_id), 32'(sid));
                chk("hold_last", 32'(report_last), 32'(slast));
            end
            if (token_clear) clr_cnt++;
            if (origin != '0) org_cnt++;
            if (token_clear && origin != '0) overlap++;
            if (deadlock_flag && report_valid) early_dl++;
            token_vec = (c < MAXC) ? tv[c] : '0;
            case (mode)
                0: report_ready = 1'b1;
                1: report_ready = (clr_cnt > 0);
                default: report_ready = 1'($urandom_range(0, 1));
            endcase
            if (report_valid && report_ready) begin
                got_id.push_back(int'(report_proc_id));
                got_last.push_back(report_last);
            end
            stall = report_valid && !report_ready;
            sid = report_proc_id;
            slast = report_last;
            if (clr_cnt > 0 && !report_valid) after++;
            else after = 0;
            if (after >= 4) done = 1'b1;
        end
        token_vec = '0;
        chk({name, "_finished"}, 32'(done), 1);
        chk({name, "_entries"}, 32'(got_id.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_id.size() && i < exp_q.size(); i++) begin
            chk({name, "_id"}, 32'(got_id[i]), 32'(exp_q[i]));
            chk({name, "_last"}, 32'(got_last[i]), 32'(i == exp_q.size() - 1));
        end
        chk({name, "_clear_pulses"}, 32'(clr_cnt), 1);
        chk({name, "_extra_origin"}, 32'(org_cnt), 0);
        chk({name, "_origin_clear_overlap"}, 32'(overlap), 0);
        chk({name, "_deadlock_before_drain"}, 32'(early_dl), 0);
        chk({name, "_deadlock_flag"}, 32'(deadlock_flag), 32'(!exp_to));
        chk({name, "_timeout_flag"}, 32'(timeout_flag), 32'(exp_to));
        chk({name, "_global"}, 32'(dl_detect_global), 1);
        $display("trace %s: origin %0d, %0d entries received, %0d expected, timeout %0d",
                 name, exp_q[0], got_id.size(), exp_q.size(), exp_to);
    endtask

    initial begin
        int rise, ocnt;
        logic [PN-1:0] oval;
        int orig, len;
        bit to_case;
        int gcnt;

        tbl[0] = '{4'b0100, 10, 1'b0, 4'b0000, 0};
        tbl[1] = '{4'b0110, 30, 1'b1, 4'b0010, 17};
        tbl[2] = '{4'b1000, 16, 1'b0, 4'b0000, 0};
        tbl[3] = '{4'b1000, 17, 1'b1, 4'b1000, 17};
        tbl[4] = '{4'b1111, 20, 1'b1, 4'b0001, 17};
        tbl[5] = '{4'b0000, 5,  1'b0, 4'b0000, 0};

        reset = 1'b0;
        dl_detect_vec = '0;
        token_vec = '0;
        report_ready = 1'b0;
        #1;
        chk("rst_global", 32'(dl_detect_global), 0);
        chk("rst_origin", 32'(origin), 0);
        chk("rst_clear", 32'(token_clear), 0);
        chk("rst_valid", 32'(report_valid), 0);
        chk("rst_last", 32'(report_last), 0);
        chk("rst_deadlock", 32'(deadlock_flag), 0);
        chk("rst_timeout", 32'(timeout_flag), 0);

        // Confirmation table: detect bit held for 'hold' cycles after IDLE sees it.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            dl_detect_vec = tbl[t].dl;
            rise = 0; ocnt = 0; oval = '0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clock); #1;
                if (dl_detect_global && rise == 0) rise = k;
                if (origin != '0) begin
                    ocnt++;
                    oval |= origin;
                    chk("origin_at_rise", 32'(k), 32'(tbl[t].exp_rise));
                end
                if (k == tbl[t].hold) dl_detect_vec = '0;
            end
            chk("tbl_global", 32'(dl_detect_global), 32'(tbl[t].exp_g));
            chk("tbl_rise_cycle", 32'(rise), 32'(tbl[t].exp_rise));
            chk("tbl_origin", 32'(oval), 32'(tbl[t].exp_o));
            chk("tbl_origin_pulses", 32'(ocnt), 32'(tbl[t].exp_g));
            $display("vector %0d: dl=%b hold=%0d global=%0d origin=%b rise=%0d",
                     t, tbl[t].dl, tbl[t].hold, dl_detect_global, oval, rise);
        end

        // Directed walk 3, 0, back to 1 with ready always high, then stalled until clear.
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < MAXC; c++) tv[c] = '0;
            tv[2] = 4'b1000;
            tv[4] = 4'b0001;
            tv[6] = 4'b0010;
            exp_q = '{1, 3, 0};
            exp_to = 1'b0;
            launch(1);
            run_trace(m, (m == 0) ? "walk_ready" : "walk_stalled");
        end

        // No token activity: timeout with origin as the only entry.
        for (int c = 0; c < MAXC; c++) tv[c] = '0;
        exp_q = '{3};
        exp_to = 1'b1;
        launch(3);
        run_trace(0, "timeout");

        // Randomized traces checked against the list-level model.
        for (int r = 0; r < 20; r++) begin
            orig = $urandom_range(0, PN - 1);
            len = $urandom_range(2, 12);
            to_case = ($urandom_range(0, 4) == 0);
            for (int c = 0; c < MAXC; c++) tv[c] = '0;
            for (int c = 1; c <= len; c++) begin
                if ($urandom_range(0, 1) == 1) tv[c] = PN'($urandom) & ~PN'(1 << orig);
            end
            if (!to_case) tv[len + 1] = PN'(1 << orig) | PN'($urandom);
            model(orig);
            launch(orig);
            run_trace(2, "random");
        end

        // Asynchronous reset in the middle of a trace.
        for (int c = 0; c < MAXC; c++) tv[c] = '0;
        launch(2);
        repeat (5) begin @(posedge clock); #1; end
        chk("pre_reset_global", 32'(dl_detect_global), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_global", 32'(dl_detect_global), 0);
        chk("async_origin", 32'(origin), 0);
        chk("async_clear", 32'(token_clear), 0);
        chk("async_valid", 32'(report_valid), 0);
        chk("async_id", 32'(report_proc_id), 0);
        chk("async_last", 32'(report_last), 0);
        chk("async_deadlock", 32'(deadlock_flag), 0);
        chk("async_timeout", 32'(timeout_flag), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        dl_detect_vec = '0;
        gcnt = 0; ocnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock); #1;
            if (dl_detect_global) gcnt++;
            if (origin != '0) ocnt++;
        end
        chk("post_reset_idle_global", 32'(gcnt), 0);
        chk("post_reset_idle_origin", 32'(ocnt), 0);
        $display("reset mid-trace: global cycles %0d, origin cycles %0d after release", gcnt, ocnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
